// File: rtl/rx_frame_packer.sv
// Interleaves per-channel DDC I/Q samples into a circular 16-bit word buffer as
// fixed-size frames (sample groups, optional 48-bit timestamp, frame counter word).
module rx_frame_packer #(
  parameter int V_RX_CHANS = 4,
  parameter int IQ_W       = 24,
  parameter int BUF_AW     = 13
) (
  input  logic                         adc_clk,
  input  logic                         reset_n,
  input  logic [V_RX_CHANS*2*IQ_W-1:0] rxn_dout,
  input  logic                         rx_avail,
  input  logic [47:0]                  ticks,
  input  logic [7:0]                   nrx_samps,
  input  logic [V_RX_CHANS-1:0]        chan_en,
  input  logic                         use_ts,
  input  logic                         soft_clr,
  input  logic                         rd_req,
  output logic [15:0]                  rd_data,
  output logic                         rd_valid,
  output logic [BUF_AW:0]              level,
  output logic                         frame_srq,
  input  logic                         srq_ack,
  output logic [15:0]                  buf_ctr,
  output logic [15:0]                  drop_cnt,
  output logic                         overrun,
  output logic                         late,
  output logic                         busy
);

  localparam int W     = (IQ_W == 24) ? 3 : 2;
  localparam int WIW   = $clog2(W);
  localparam int CW    = (V_RX_CHANS > 1) ? $clog2(V_RX_CHANS) : 1;
  localparam int DEPTH = 1 << BUF_AW;

  typedef enum logic [2:0] {IDLE, MOVE, WAIT, TS, CTR} state_t;

  // All clearable state lives in one record so reset and soft_clr share one path.
  typedef struct packed {
    state_t                  state;
    logic [CW-1:0]           chan;
    logic [WIW-1:0]          word_idx;
    logic [7:0]              samp_idx;
    logic [1:0]              ts_idx;
    logic [7:0]              cfg_n;
    logic [V_RX_CHANS-1:0]   cfg_en;
    logic                    cfg_ts;
    logic                    drop_frame;
    logic [47:0]             ts_lat;
    logic [BUF_AW-1:0]       wr_ptr;
    logic [BUF_AW-1:0]       rd_ptr;
    logic [BUF_AW:0]         level;
    logic                    rd_valid;
    logic                    frame_srq;
    logic [15:0]             buf_ctr;
    logic [15:0]             drop_cnt;
    logic                    overrun;
    logic                    late;
    logic                    busy;
  } ctl_t;

  ctl_t        ctl;
  logic [15:0] chan_word [V_RX_CHANS][W];
  logic [15:0] mem [DEPTH];
  logic [15:0] ram_q;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        pop;
  logic [4:0]  en_cnt;
  logic [15:0] frame_words;
  logic [31:0] free_words;
  logic        fits;

  for (genvar gi = 0; gi < V_RX_CHANS; gi++) begin : g_chan
    localparam int B = gi * 2 * IQ_W;
    assign chan_word[gi][0] = rxn_dout[B +: 16];
    assign chan_word[gi][1] = rxn_dout[B + IQ_W +: 16];
    if (W == 3) begin : g_hi
      assign chan_word[gi][2] = {rxn_dout[B + 16 +: 8], rxn_dout[B + IQ_W + 16 +: 8]};
    end
  end

  always_comb begin
    en_cnt = '0;
    for (int i = 0; i < V_RX_CHANS; i++) en_cnt = en_cnt + {4'd0, chan_en[i]};
    frame_words = 16'(nrx_samps) * 16'(en_cnt) * 16'(W) + (use_ts ? 16'd4 : 16'd1);
    free_words  = 32'(DEPTH) - 32'(ctl.level);
    fits        = free_words >= 32'(frame_words);
  end

  assign pop = rd_req && (ctl.level != '0);

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    case (ctl.state)
      MOVE: begin
        wr_en   = ctl.cfg_en[ctl.chan] && !ctl.drop_frame;
        wr_data = chan_word[ctl.chan][ctl.word_idx];
      end
      TS: begin
        wr_en = !ctl.drop_frame;
        case (ctl.ts_idx)
          2'd0:    wr_data = ctl.ts_lat[15:0];
          2'd1:    wr_data = ctl.ts_lat[31:16];
          default: wr_data = ctl.ts_lat[47:32];
        endcase
      end
      CTR: begin
        wr_en   = !ctl.drop_frame;
        wr_data = ctl.buf_ctr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (wr_en) mem[ctl.wr_ptr] <= wr_data;
    if (pop) ram_q <= mem[ctl.rd_ptr];
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl <= '0;
    end else if (soft_clr) begin
      ctl <= '0;
    end else begin
      if (wr_en) ctl.wr_ptr <= ctl.wr_ptr + 1'b1;
      if (pop)   ctl.rd_ptr <= ctl.rd_ptr + 1'b1;
      ctl.level    <= ctl.level + {{BUF_AW{1'b0}}, wr_en} - {{BUF_AW{1'b0}}, pop};
      ctl.rd_valid <= pop;
      if (srq_ack) ctl.frame_srq <= 1'b0;

      case (ctl.state)
        IDLE: begin
          if (rx_avail && nrx_samps != 8'd0 && chan_en != '0) begin
            ctl.state      <= MOVE;
            ctl.busy       <= 1'b1;
            ctl.chan       <= '0;
            ctl.word_idx   <= '0;
            ctl.samp_idx   <= '0;
            ctl.cfg_n      <= nrx_samps;
            ctl.cfg_en     <= chan_en;
            ctl.cfg_ts     <= use_ts;
            ctl.ts_lat     <= ticks;
            ctl.drop_frame <= !fits;
            if (!fits) begin
              ctl.overrun <= 1'b1;
              if (ctl.drop_cnt != 16'hFFFF) ctl.drop_cnt <= ctl.drop_cnt + 16'd1;
            end
          end
        end
        MOVE: begin
          if (rx_avail) ctl.late <= 1'b1;
          if (ctl.cfg_en[ctl.chan] && ctl.word_idx != WIW'(W - 1)) begin
            ctl.word_idx <= ctl.word_idx + 1'b1;
          end else begin
            ctl.word_idx <= '0;
            if (ctl.chan == CW'(V_RX_CHANS - 1)) begin
              ctl.chan <= '0;
              if (ctl.samp_idx != ctl.cfg_n - 8'd1) begin
                ctl.state    <= WAIT;
                ctl.samp_idx <= ctl.samp_idx + 8'd1;
              end else begin
                ctl.state  <= ctl.cfg_ts ? TS : CTR;
                ctl.ts_idx <= 2'd0;
              end
            end else begin
              ctl.chan <= ctl.chan + 1'b1;
            end
          end
        end
        WAIT: begin
          // Each accepted pulse refreshes the stamp, so the last group's value survives.
          if (rx_avail) begin
            ctl.state  <= MOVE;
            ctl.ts_lat <= ticks;
          end
        end
        TS: begin
          if (rx_avail) ctl.late <= 1'b1;
          ctl.ts_idx <= ctl.ts_idx + 2'd1;
          if (ctl.ts_idx == 2'd2) ctl.state <= CTR;
        end
        CTR: begin
          if (rx_avail) ctl.late <= 1'b1;
          ctl.state <= IDLE;
          ctl.busy  <= 1'b0;
          if (!ctl.drop_frame) begin
            ctl.buf_ctr   <= ctl.buf_ctr + 16'd1;
            ctl.frame_srq <= 1'b1;
          end
        end
        default: begin
          ctl.state <= IDLE;
          ctl.busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data   = ctl.rd_valid ? ram_q : 16'h0000;
  assign rd_valid  = ctl.rd_valid;
  assign level     = ctl.level;
  assign frame_srq = ctl.frame_srq;
  assign buf_ctr   = ctl.buf_ctr;
  assign drop_cnt  = ctl.drop_cnt;
  assign overrun   = ctl.overrun;
  assign late      = ctl.late;
  assign busy      = ctl.busy;

endmodule

// File: tb/tb_rx_frame_packer.sv
// Directed bench for rx_frame_packer: a 16-bit and a 24-bit instance, each with a 32-word buffer.
module tb_rx_frame_packer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [127:0] rxn16 = '0;
  logic [191:0] rxn24 = '0;
  logic         rx_avail = 1'b0;
  logic [47:0]  ticks = '0;
  logic [7:0]   nrx_samps = '0;
  logic [3:0]   chan_en = '0;
  logic         use_ts = 1'b0;
  logic         soft_clr = 1'b0;
  logic         rd_req16 = 1'b0;
  logic         rd_req24 = 1'b0;
  logic         srq_ack = 1'b0;

  logic [15:0]  rd_data16, rd_data24, buf_ctr16, buf_ctr24, drop_cnt16, drop_cnt24;
  logic         rd_valid16, rd_valid24, frame_srq16, frame_srq24;
  logic         overrun16, overrun24, late16, late24, busy16, busy24;
  logic [5:0]   level16, level24;

  int total = 0;
  int bad = 0;
  int model_ctr = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  rx_frame_packer #(.V_RX_CHANS(4), .IQ_W(16), .BUF_AW(5)) u_dut16 (
    .adc_clk(clk), .reset_n(reset_n), .rxn_dout(rxn16), .rx_avail(rx_avail), .ticks(ticks),
    .nrx_samps(nrx_samps), .chan_en(chan_en), .use_ts(use_ts), .soft_clr(soft_clr),
    .rd_req(rd_req16), .rd_data(rd_data16), .rd_valid(rd_valid16), .level(level16),
    .frame_srq(frame_srq16), .srq_ack(srq_ack), .buf_ctr(buf_ctr16), .drop_cnt(drop_cnt16),
    .overrun(overrun16), .late(late16), .busy(busy16));

  rx_frame_packer #(.V_RX_CHANS(4), .IQ_W(24), .BUF_AW(5)) u_dut24 (
    .adc_clk(clk), .reset_n(reset_n), .rxn_dout(rxn24), .rx_avail(rx_avail), .ticks(ticks),
    .nrx_samps(nrx_samps), .chan_en(chan_en), .use_ts(use_ts), .soft_clr(soft_clr),
    .rd_req(rd_req24), .rd_data(rd_data24), .rd_valid(rd_valid24), .level(level24),
    .frame_srq(frame_srq24), .srq_ack(srq_ack), .buf_ctr(buf_ctr24), .drop_cnt(drop_cnt24),
    .overrun(overrun24), .late(late24), .busy(busy24));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    rx_avail = 1'b1;
    step();
    rx_avail = 1'b0;
  endtask

  task automatic do_clear();
    soft_clr = 1'b1;
    step();
    soft_clr = 1'b0;
    model_ctr = 0;
    exp_q.delete();
  endtask

  task automatic set_sample16(input int s);
    for (int c = 0; c < 4; c++) begin
      rxn16[c*32 +: 16]      = 16'(16'h1000 + s * 16 + c);
      rxn16[c*32 + 16 +: 16] = 16'(16'h2000 + s * 16 + c);
    end
  endtask

  task automatic push_expected(input int n, input logic [3:0] en, input logic ts_on, input logic [47:0] tsv);
    for (int s = 0; s < n; s++)
      for (int c = 0; c < 4; c++)
        if (en[c]) begin
          exp_q.push_back(16'(16'h1000 + s * 16 + c));
          exp_q.push_back(16'(16'h2000 + s * 16 + c));
        end
    if (ts_on) begin
      exp_q.push_back(tsv[15:0]);
      exp_q.push_back(tsv[31:16]);
      exp_q.push_back(tsv[47:32]);
    end
    exp_q.push_back(16'(model_ctr));
    model_ctr++;
  endtask

  task automatic run_frame16(input int n, input logic [3:0] en, input logic ts_on, input logic accepted);
    nrx_samps = 8'(n);
    chan_en   = en;
    use_ts    = ts_on;
    for (int s = 0; s < n; s++) begin
      set_sample16(s);
      ticks = {16'(16'hA000 + s), 16'(16'hB000 + model_ctr), 16'(16'hC000 + s)};
      pulse();
      repeat (20) step();
    end
    if (accepted) push_expected(n, en, ts_on, ticks);
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++; if (level16 !== 6'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level16); end
    total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy16); end
    total++; if ({frame_srq16, overrun16, late16, rd_valid16} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {frame_srq16, overrun16, late16, rd_valid16}); end
    total++; if ({buf_ctr16, drop_cnt16, rd_data16} !== 48'd0) begin bad++; $display("FAIL reset_counters got=%h exp=0", {buf_ctr16, drop_cnt16, rd_data16}); end
    reset_n = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_clear();
    run_frame16(2, 4'hF, 1'b1, 1'b1);
    total++; if (level16 !== 6'd20) begin bad++; $display("FAIL basic_level got=%0d exp=20", level16); end
    total++; if (buf_ctr16 !== 16'd1) begin bad++; $display("FAIL basic_buf_ctr got=%0d exp=1", buf_ctr16); end
    total++; if (frame_srq16 !== 1'b1) begin bad++; $display("FAIL basic_frame_srq got=%b exp=1", frame_srq16); end
    total++; if (exp_q[19] !== 16'h0000) begin bad++; $display("FAIL basic_model_last got=%h exp=0000", exp_q[19]); end
    rd_req16 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      total++;
      if (rd_valid16 !== 1'b1 || rd_data16 !== exp_q[0]) begin
        bad++; $display("FAIL basic_word%0d got=%h valid=%b exp=%h", k, rd_data16, rd_valid16, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    rd_req16 = 1'b0;
    $display("test_basic done level=%0d", level16);
  endtask

  task automatic test_srq_ack();
    bit done = 0;
    do_clear();
    nrx_samps = 8'd1; chan_en = 4'h1; use_ts = 1'b0;
    set_sample16(0);
    pulse();
    srq_ack = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (!busy16) done = 1;
    end
    total++; if (!done) begin bad++; $display("FAIL srq_timeout got=busy exp=idle"); end
    total++; if (frame_srq16 !== 1'b1) begin bad++; $display("FAIL srq_set_wins got=%b exp=1", frame_srq16); end
    step();
    total++; if (frame_srq16 !== 1'b0) begin bad++; $display("FAIL srq_ack_clear got=%b exp=0", frame_srq16); end
    srq_ack = 1'b0;
    $display("test_srq_ack done");
  endtask

  task automatic test_pack24();
    logic [15:0] exp24 [4];
    exp24[0] = 16'hCDEF; exp24[1] = 16'h3456; exp24[2] = 16'hAB12; exp24[3] = 16'h0000;
    do_clear();
    rxn24 = '0;
    rxn24[47:0] = {24'h123456, 24'hABCDEF};
    nrx_samps = 8'd1; chan_en = 4'h1; use_ts = 1'b0;
    pulse();
    repeat (15) step();
    total++; if (level24 !== 6'd4) begin bad++; $display("FAIL pack24_level got=%0d exp=4", level24); end
    rd_req24 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (rd_valid24 !== 1'b1 || rd_data24 !== exp24[k]) begin
        bad++; $display("FAIL pack24_word%0d got=%h valid=%b exp=%h", k, rd_data24, rd_valid24, exp24[k]);
      end
    end
    rd_req24 = 1'b0;
    $display("test_pack24 done");
  endtask

  task automatic test_mask();
    int bc;
    do_clear();
    nrx_samps = 8'd1; chan_en = 4'b0101; use_ts = 1'b0;
    set_sample16(0);
    pulse();
    bc = busy16 ? 1 : 0;
    repeat (20) begin step(); if (busy16) bc++; end
    total++; if (bc != 7) begin bad++; $display("FAIL mask_busy_cycles got=%0d exp=7", bc); end
    total++; if (level16 !== 6'd5) begin bad++; $display("FAIL mask_level got=%0d exp=5", level16); end
    push_expected(1, 4'b0101, 1'b0, 48'd0);
    rd_req16 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (rd_valid16 !== 1'b1 || rd_data16 !== exp_q[0]) begin
        bad++; $display("FAIL mask_word%0d got=%h valid=%b exp=%h", k, rd_data16, rd_valid16, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    rd_req16 = 1'b0;
    $display("test_mask done");
  endtask

  task automatic test_inert();
    do_clear();
    nrx_samps = 8'd0; chan_en = 4'hF;
    pulse();
    total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL inert_n0_busy got=%b exp=0", busy16); end
    nrx_samps = 8'd2; chan_en = 4'h0;
    pulse();
    repeat (5) step();
    total++; if ({busy16, level16, late16} !== 8'd0) begin bad++; $display("FAIL inert_en0 got=%h exp=0", {busy16, level16, late16}); end
    $display("test_inert done");
  endtask

  task automatic test_overrun();
    do_clear();
    run_frame16(2, 4'hF, 1'b1, 1'b1);
    run_frame16(2, 4'hF, 1'b1, 1'b0);
    total++; if (drop_cnt16 !== 16'd1) begin bad++; $display("FAIL ovr_drop_cnt got=%0d exp=1", drop_cnt16); end
    total++; if (overrun16 !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun16); end
    total++; if (level16 !== 6'd20) begin bad++; $display("FAIL ovr_level got=%0d exp=20", level16); end
    total++; if (buf_ctr16 !== 16'd1) begin bad++; $display("FAIL ovr_buf_ctr got=%0d exp=1", buf_ctr16); end
    rd_req16 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      total++;
      if (rd_valid16 !== 1'b1 || rd_data16 !== exp_q[0]) begin
        bad++; $display("FAIL ovr_first_word%0d got=%h valid=%b exp=%h", k, rd_data16, rd_valid16, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    rd_req16 = 1'b0;
    run_frame16(2, 4'hF, 1'b1, 1'b1);
    total++; if (level16 !== 6'd20) begin bad++; $display("FAIL ovr_third_level got=%0d exp=20", level16); end
    rd_req16 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      total++;
      if (rd_valid16 !== 1'b1 || rd_data16 !== exp_q[0]) begin
        bad++; $display("FAIL ovr_third_word%0d got=%h valid=%b exp=%h", k, rd_data16, rd_valid16, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    rd_req16 = 1'b0;
    total++; if (rd_data16 !== 16'd1) begin bad++; $display("FAIL ovr_third_ctr got=%h exp=0001", rd_data16); end
    $display("test_overrun done drop_cnt=%0d", drop_cnt16);
  endtask

  task automatic test_late();
    do_clear();
    nrx_samps = 8'd2; chan_en = 4'hF; use_ts = 1'b0;
    set_sample16(0);
    pulse();
    repeat (2) step();
    pulse();
    total++; if (late16 !== 1'b1) begin bad++; $display("FAIL late_flag got=%b exp=1", late16); end
    repeat (20) step();
    total++; if (busy16 !== 1'b1 || level16 !== 6'd8) begin bad++; $display("FAIL late_ignored got=busy%b/lvl%0d exp=busy1/lvl8", busy16, level16); end
    set_sample16(1);
    pulse();
    repeat (20) step();
    total++; if (level16 !== 6'd17 || buf_ctr16 !== 16'd1) begin bad++; $display("FAIL late_frame got=lvl%0d/ctr%0d exp=lvl17/ctr1", level16, buf_ctr16); end
    push_expected(2, 4'hF, 1'b0, 48'd0);
    rd_req16 = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      total++;
      if (rd_valid16 !== 1'b1 || rd_data16 !== exp_q[0]) begin
        bad++; $display("FAIL late_word%0d got=%h valid=%b exp=%h", k, rd_data16, rd_valid16, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    rd_req16 = 1'b0;
    $display("test_late done");
  endtask

  task automatic test_wrap();
    rd_req16 = 1'b1;
    step();
    rd_req16 = 1'b0;
    total++; if (rd_valid16 !== 1'b0 || level16 !== 6'd0) begin bad++; $display("FAIL empty_pop got=valid%b/lvl%0d exp=valid0/lvl0", rd_valid16, level16); end
    for (int f = 0; f < 5; f++) begin
      run_frame16(2, 4'hF, 1'b0, 1'b1);
      rd_req16 = 1'b1;
      for (int k = 0; k < 17; k++) begin
        step();
        total++;
        if (rd_valid16 !== 1'b1 || rd_data16 !== exp_q[0]) begin
          bad++; $display("FAIL wrap_f%0d_word%0d got=%h valid=%b exp=%h", f, k, rd_data16, rd_valid16, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      rd_req16 = 1'b0;
    end
    $display("test_wrap done buf_ctr=%0d", buf_ctr16);
  endtask

  task automatic test_clear_mid();
    do_clear();
    nrx_samps = 8'd2; chan_en = 4'hF; use_ts = 1'b1;
    set_sample16(0);
    pulse();
    repeat (3) step();
    total++; if (busy16 !== 1'b1 || level16 !== 6'd3) begin bad++; $display("FAIL clr_pre got=busy%b/lvl%0d exp=busy1/lvl3", busy16, level16); end
    soft_clr = 1'b1;
    step();
    soft_clr = 1'b0;
    total++; if ({busy16, level16} !== 7'd0) begin bad++; $display("FAIL clr_state got=busy%b/lvl%0d exp=0/0", busy16, level16); end
    total++; if ({buf_ctr16, drop_cnt16, frame_srq16, overrun16, late16, rd_valid16} !== 36'd0) begin
      bad++; $display("FAIL clr_outputs got=%h exp=0", {buf_ctr16, drop_cnt16, frame_srq16, overrun16, late16, rd_valid16});
    end
    repeat (20) step();
    total++; if ({busy16, level16} !== 7'd0) begin bad++; $display("FAIL clr_abandon got=busy%b/lvl%0d exp=0/0", busy16, level16); end
    $display("test_clear_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_srq_ack();
    test_pack24();
    test_mask();
    test_inert();
    test_overrun();
    test_late();
    test_wrap();
    test_clear_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
